board_cell_picker: RTL

BOARD_CELL_PICKER -- requirements
Module: board_cell_picker

---
 rtl/board_pkg.sv | 30 +++
 rtl/cell_index_decoder.sv | 15 +
 rtl/board_cell_picker.sv | 123 ++++++++++++
 3 files changed

// File: rtl/board_pkg.sv
// Shared constants, FSM state type and cell-index helpers
// for the board cell picker.
package board_pkg;

    localparam int BOARD_CELLS = 64;
    localparam int CELL_W      = 6;
    localparam int ROW_W       = 3;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REQ    = 3'd1,
        S_SAMPLE = 3'd2,
        S_CHECK  = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    typedef struct packed {
        logic [ROW_W-1:0] row;
        logic [ROW_W-1:0] col;
    } cell_pos_t;

    // Upper bits of the index select the row, lower bits the column.
    function automatic cell_pos_t split_cell(input logic [CELL_W-1:0] idx);
        cell_pos_t p;
        p.row = idx[CELL_W-1:ROW_W];
        p.col = idx[ROW_W-1:0];
        return p;
    endfunction

endpackage

// File: rtl/cell_index_decoder.sv
// Cell index to one-hot occupancy mask.
// Pure combinational; one bit per board cell.
module cell_index_decoder
    import board_pkg::*;
(
    input  logic [CELL_W-1:0]      idx,
    output logic [BOARD_CELLS-1:0] onehot
);

    localparam logic [BOARD_CELLS-1:0] ONE = BOARD_CELLS'(1);

    // Shift a single set bit into the selected cell position.
    assign onehot = ONE << idx;

endmodule

// File: rtl/board_cell_picker.sv
// Places a requested number of distinct random cells on a
// 64-cell board, redrawing duplicates up to a retry limit.
module board_cell_picker
    import board_pkg::*;
#(
    parameter int MAX_CELLS   = 15,
    parameter int RETRY_LIMIT = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [3:0]             count,
    input  logic [CELL_W-1:0]      rand_val,
    output logic                   rand_req,
    output logic                   busy,
    output logic                   cell_valid,
    output logic [ROW_W-1:0]       cell_row,
    output logic [ROW_W-1:0]       cell_col,
    output logic [BOARD_CELLS-1:0] cell_map,
    output logic                   done,
    output logic                   err
);

    localparam int RW = $clog2(RETRY_LIMIT + 1);
    localparam logic [3:0]    MAX_CNT   = 4'(MAX_CELLS);
    localparam logic [RW-1:0] RETRY_MAX = RW'(RETRY_LIMIT);

    state_t                   state;
    logic [3:0]               target;
    logic [3:0]               placed;
    logic [RW-1:0]            retry;
    logic [CELL_W-1:0]        sample;
    logic                     abort;
    logic [BOARD_CELLS-1:0]   onehot;
    logic                     hit;
    cell_pos_t                pos;
    logic [3:0]               cnt_clamped;
    logic [3:0]               placed_inc;
    logic [RW-1:0]            retry_inc;

    cell_index_decoder u_dec (
        .idx    (sample),
        .onehot (onehot)
    );

    assign hit         = |(cell_map & onehot);
    assign pos         = split_cell(sample);
    assign cnt_clamped = (count > MAX_CNT) ? MAX_CNT : count;
    assign placed_inc  = placed + 4'd1;
    assign retry_inc   = retry + RW'(1);

    assign rand_req = (state == S_REQ);
    assign busy     = (state != S_IDLE);

    // Placement FSM: request, sample, check, then finish or redraw.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            target     <= '0;
            placed     <= '0;
            retry      <= '0;
            sample     <= '0;
            abort      <= 1'b0;
            err        <= 1'b0;
            done       <= 1'b0;
            cell_valid <= 1'b0;
            cell_row   <= '0;
            cell_col   <= '0;
            cell_map   <= '0;
        end else begin
            cell_valid <= 1'b0;
            done       <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        cell_map <= '0;
                        err      <= 1'b0;
                        abort    <= 1'b0;
                        target   <= cnt_clamped;
                        placed   <= '0;
                        retry    <= '0;
                        state    <= (cnt_clamped == 4'd0) ? S_FINISH : S_REQ;
                    end
                end
                S_REQ: begin
                    state <= S_SAMPLE;
                end
                S_SAMPLE: begin
                    sample <= rand_val;
                    state  <= S_CHECK;
                end
                S_CHECK: begin
                    if (hit) begin
                        retry <= retry_inc;
                        if (retry_inc == RETRY_MAX) begin
                            abort <= 1'b1;
                            state <= S_FINISH;
                        end else begin
                            state <= S_REQ;
                        end
                    end else begin
                        cell_map   <= cell_map | onehot;
                        cell_valid <= 1'b1;
                        cell_row   <= pos.row;
                        cell_col   <= pos.col;
                        placed     <= placed_inc;
                        retry      <= '0;
                        state      <= (placed_inc == target) ? S_FINISH : S_REQ;
                    end
                end
                S_FINISH: begin
                    done  <= 1'b1;
                    err   <= abort;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
